// File: rtl/game_pkg.sv
// Shared types for the Sokoban undo controller: move directions, history entry and FSM states.
// Optional redo support in game_undo_ctrl is enabled by defining GAME_UNDO_REDO_EN.
package game_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int unsigned ENTRY_W = 3;

  typedef struct packed {
    logic       pushed;
    logic [1:0] dir;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

endpackage

// File: rtl/game_hist_ram.sv
// Move-history storage: DEPTH x 3-bit array, synchronous write, registered read.
// Pointer management lives entirely in game_undo_ctrl.
module game_hist_ram
  import game_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned PTR_BITS = 6
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [PTR_BITS-1:0] waddr_i,
  input  entry_t              wdata_i,
  input  logic                re_i,
  input  logic [PTR_BITS-1:0] raddr_i,
  output entry_t              rdata_o
);

  entry_t mem_q [DEPTH];
  entry_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/game_undo_ctrl.sv
// Sokoban move-history controller: circular LIFO of committed moves, undo over valid/ack,
// step counter pulses. Define GAME_UNDO_REDO_EN to add redo support.
module game_undo_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned PTR_BITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              level_reset,
  input  logic              move_valid,
  input  logic [1:0]        move_dir,
  input  logic              move_pushed,
  output logic              move_ready,
  input  logic              undo_req,
  output logic              undo_valid,
  output logic [1:0]        undo_dir,
  output logic              undo_pushed,
  input  logic              undo_ack,
`ifdef GAME_UNDO_REDO_EN
  input  logic              redo_req,
  output logic [PTR_BITS:0] redo_count,
  output logic              is_redo,
`endif
  output logic              undo_reject,
  output logic              step_inc,
  output logic              step_dec,
  output logic              step_rst,
  output logic [PTR_BITS:0] depth,
  output logic              empty,
  output logic              full
);

  localparam logic [PTR_BITS:0]   DEPTH_W = (PTR_BITS+1)'(DEPTH);
  localparam logic [PTR_BITS:0]   CNT_ONE = (PTR_BITS+1)'(1);
  localparam logic [PTR_BITS-1:0] PTR_ONE = PTR_BITS'(1);

  state_e              state_q;
  logic [PTR_BITS-1:0] head_q;
  logic [PTR_BITS:0]   depth_q;
  logic [PTR_BITS:0]   depth_inc_d;
  entry_t              undo_entry_q;
  logic                undo_valid_q;
  logic                undo_reject_q;
  logic                step_inc_q;
  logic                step_dec_q;
  logic                step_rst_q;

  logic                is_idle;
  logic                mv_acc;
  logic                undo_go;
  logic                redo_go;
  logic                reject_d;
  logic                rd_en;
  logic [PTR_BITS-1:0] rd_addr;
  entry_t              wr_entry;
  entry_t              rd_entry;

  assign is_idle     = (state_q == ST_IDLE);
  assign mv_acc      = is_idle && move_valid;
  assign undo_go     = is_idle && undo_req && !move_valid && (depth_q != '0);
  assign depth_inc_d = (depth_q == DEPTH_W) ? depth_q : depth_q + CNT_ONE;
  assign wr_entry    = '{pushed: move_pushed, dir: move_dir};

`ifdef GAME_UNDO_REDO_EN
  logic [PTR_BITS:0] redo_cnt_q;
  logic              is_redo_q;
  logic              redo_cap_ok;

  assign redo_go     = is_idle && redo_req && !undo_req && !move_valid && (redo_cnt_q != '0);
  assign reject_d    = (undo_req && !undo_go) || (redo_req && !redo_go && !undo_go);
  // Undo + redo never exceed DEPTH, so a redo slot is only granted while the sum fits.
  assign redo_cap_ok = ({1'b0, redo_cnt_q} + {1'b0, depth_q}) <= {1'b0, DEPTH_W};
  assign redo_count  = redo_cnt_q;
  assign is_redo     = is_redo_q && undo_valid_q;
`else
  assign redo_go     = 1'b0;
  assign reject_d    = undo_req && !undo_go;
`endif

  // A redo re-reads the slot at head that the last undo left intact.
  assign rd_en   = undo_go || redo_go;
  assign rd_addr = redo_go ? head_q : head_q - PTR_ONE;

  game_hist_ram #(
    .DEPTH   (DEPTH),
    .PTR_BITS(PTR_BITS)
  ) u_hist (
    .clk    (clk),
    .we_i   (mv_acc),
    .waddr_i(head_q),
    .wdata_i(wr_entry),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .rdata_o(rd_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      head_q        <= '0;
      depth_q       <= '0;
      undo_entry_q  <= '0;
      undo_valid_q  <= 1'b0;
      undo_reject_q <= 1'b0;
      step_inc_q    <= 1'b0;
      step_dec_q    <= 1'b0;
      step_rst_q    <= 1'b0;
`ifdef GAME_UNDO_REDO_EN
      redo_cnt_q    <= '0;
      is_redo_q     <= 1'b0;
`endif
    end else if (level_reset) begin
      state_q       <= ST_IDLE;
      head_q        <= '0;
      depth_q       <= '0;
      undo_valid_q  <= 1'b0;
      undo_reject_q <= 1'b0;
      step_inc_q    <= 1'b0;
      step_dec_q    <= 1'b0;
      step_rst_q    <= 1'b1;
`ifdef GAME_UNDO_REDO_EN
      redo_cnt_q    <= '0;
      is_redo_q     <= 1'b0;
`endif
    end else begin
      undo_reject_q <= reject_d;
      step_inc_q    <= mv_acc;
      step_dec_q    <= 1'b0;
      step_rst_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mv_acc) begin
            head_q  <= head_q + PTR_ONE;
            depth_q <= depth_inc_d;
`ifdef GAME_UNDO_REDO_EN
            redo_cnt_q <= '0;
`endif
          end else if (rd_en) begin
            state_q <= ST_RD;
`ifdef GAME_UNDO_REDO_EN
            is_redo_q <= redo_go;
`endif
          end
        end
        ST_RD: begin
          undo_entry_q <= rd_entry;
          undo_valid_q <= 1'b1;
          state_q      <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (undo_ack) begin
            undo_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
`ifdef GAME_UNDO_REDO_EN
            is_redo_q    <= 1'b0;
            if (is_redo_q) begin
              head_q     <= head_q + PTR_ONE;
              depth_q    <= depth_inc_d;
              redo_cnt_q <= redo_cnt_q - CNT_ONE;
              step_inc_q <= 1'b1;
            end else begin
              head_q     <= head_q - PTR_ONE;
              depth_q    <= depth_q - CNT_ONE;
              step_dec_q <= 1'b1;
              if (redo_cap_ok) redo_cnt_q <= redo_cnt_q + CNT_ONE;
            end
`else
            head_q     <= head_q - PTR_ONE;
            depth_q    <= depth_q - CNT_ONE;
            step_dec_q <= 1'b1;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign move_ready  = is_idle;
  assign undo_valid  = undo_valid_q;
  assign undo_dir    = undo_entry_q.dir;
  assign undo_pushed = undo_entry_q.pushed;
  assign undo_reject = undo_reject_q;
  assign step_inc    = step_inc_q;
  assign step_dec    = step_dec_q;
  assign step_rst    = step_rst_q;
  assign depth       = depth_q;
  assign empty       = (depth_q == '0);
  assign full        = (depth_q == DEPTH_W);

endmodule
